// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master IP register port between NREQ
// requesters. Each round-robin grant runs one complete multi-byte transaction:
// SSMASK, CONTROL on, per byte {poll TX ready, TXDATA, poll RX ready, RXDATA},
// CONTROL off. Received bytes stream back to the granted requester.
//
// Ports
//   I_CLK, I_RESET            clock, synchronous active-high reset
//   req[NREQ]                 level requests, held until done
//   req_ssmask[8*NREQ]        per-requester SSMASK, captured at grant
//   req_len[4*NREQ]           per-requester byte count - 1, captured at grant
//   tx_data[8*NREQ]           per-requester next TX byte
//   gnt[NREQ]                 one-hot grant, high for the whole transaction
//   tx_take                   granted requester's current TX byte consumed
//   rx_data/rx_valid/rx_last  received byte stream
//   done/err                  end-of-transaction pulse, err on poll timeout
//   I_TX_EN/I_WADDR/I_WDATA   IP register write port
//   I_RX_EN/I_RADDR/O_RDATA   IP register read port
module spi_txn_arbiter #(
  parameter int         NREQ     = 2,
  parameter logic [7:0] CTRL_ON  = 8'h8B,
  parameter int         POLL_MAX = 255
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_ssmask,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_take,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              rx_last,
  output logic              done,
  output logic              err,
  output logic              I_TX_EN,
  output logic [2:0]        I_WADDR,
  output logic [7:0]        I_WDATA,
  output logic              I_RX_EN,
  output logic [2:0]        I_RADDR,
  input  logic [7:0]        O_RDATA
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] A_RXDATA  = 3'd0;
  localparam logic [2:0] A_TXDATA  = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_CONTROL = 3'd3;
  localparam logic [2:0] A_SSMASK  = 3'd4;

  typedef enum logic [3:0] {
    IDLE, ARB, WR_SS, WR_CTRL, POLL_TX, WR_TX, POLL_RX, RD_RX, WR_OFF, DONE
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ph;         // cycle within the current bus op
  logic [GW-1:0]   gidx, ptr;  // granted / last granted requester
  logic [7:0]      ssmask_q, rdata_q, tx_q, poll_cnt;
  logic [3:0]      cnt;
  logic            err_q;

  logic            arb_hit;
  logic [GW-1:0]   arb_idx;
  int              arb_j;
  logic [7:0]      arb_ssmask, tx_sel;
  logic [3:0]      arb_len;
  logic            is_wr, is_rd, poll_ok, poll_to;

  // Round-robin: walk from ptr+1 upward with wrap; the smallest offset wins,
  // so iterate from the largest offset down and let later hits overwrite.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr;
    arb_j   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      arb_j = (int'(ptr) + k) % NREQ;
      if (req[arb_j]) begin
        arb_hit = 1'b1;
        arb_idx = GW'(arb_j);
      end
    end
  end

  always_comb begin
    arb_ssmask = '0;
    arb_len    = '0;
    tx_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == arb_idx) begin
        arb_ssmask = req_ssmask[i*8 +: 8];
        arb_len    = req_len[i*4 +: 4];
      end
      if (GW'(i) == gidx) tx_sel = tx_data[i*8 +: 8];
    end
  end

  assign is_wr   = (state == WR_SS) || (state == WR_CTRL) || (state == WR_TX) || (state == WR_OFF);
  assign is_rd   = (state == POLL_TX) || (state == POLL_RX) || (state == RD_RX);
  assign poll_ok = (state == POLL_TX) ? (rdata_q[5] & rdata_q[4]) : rdata_q[6];
  // poll_cnt holds failures so far; the current failure is the last allowed one
  assign poll_to = (poll_cnt == 8'(POLL_MAX - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = ARB;
      ARB:     state_n = arb_hit ? WR_SS : IDLE;
      WR_SS:   if (ph == 2'd1) state_n = WR_CTRL;
      WR_CTRL: if (ph == 2'd1) state_n = POLL_TX;
      POLL_TX: if (ph == 2'd3) begin
                 if (poll_ok)      state_n = WR_TX;
                 else if (poll_to) state_n = WR_OFF;
               end
      WR_TX:   if (ph == 2'd1) state_n = POLL_RX;
      POLL_RX: if (ph == 2'd3) begin
                 if (poll_ok)      state_n = RD_RX;
                 else if (poll_to) state_n = WR_OFF;
               end
      RD_RX:   if (ph == 2'd3) state_n = (cnt == 4'd0) ? WR_OFF : POLL_TX;
      WR_OFF:  if (ph == 2'd1) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state    <= IDLE;
      ph       <= '0;
      gidx     <= '0;
      ptr      <= GW'(NREQ - 1);
      ssmask_q <= '0;
      rdata_q  <= '0;
      tx_q     <= '0;
      poll_cnt <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      // Poll retries stay in the same state; the 2-bit phase wraps 3 -> 0.
      ph    <= (state_n != state) ? 2'd0 : ph + 2'd1;
      tx_q  <= tx_sel;
      if (is_rd && ph == 2'd2) rdata_q <= O_RDATA;
      if (state == ARB && arb_hit) begin
        gidx     <= arb_idx;
        ptr      <= arb_idx;
        ssmask_q <= arb_ssmask;
        cnt      <= arb_len;
        err_q    <= 1'b0;
      end
      if (state_n != state)
        poll_cnt <= '0;
      else if ((state == POLL_TX || state == POLL_RX) && ph == 2'd3 && !poll_ok)
        poll_cnt <= poll_cnt + 8'd1;
      if ((state == POLL_TX || state == POLL_RX) && state_n == WR_OFF)
        err_q <= 1'b1;
      if (state == RD_RX && ph == 2'd3 && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    I_TX_EN  = is_wr && (ph == 2'd0);
    I_RX_EN  = is_rd && (ph == 2'd0);
    I_WADDR  = '0;
    I_WDATA  = '0;
    I_RADDR  = '0;
    if (I_TX_EN) begin
      case (state)
        WR_SS:   begin I_WADDR = A_SSMASK;  I_WDATA = ssmask_q; end
        WR_CTRL: begin I_WADDR = A_CONTROL; I_WDATA = CTRL_ON;  end
        WR_TX:   begin I_WADDR = A_TXDATA;  I_WDATA = tx_q;     end
        default: begin I_WADDR = A_CONTROL; I_WDATA = 8'h00;    end
      endcase
    end
    if (I_RX_EN) I_RADDR = (state == RD_RX) ? A_RXDATA : A_STATUS;
    tx_take  = (state == WR_TX) && (ph == 2'd0);
    rx_valid = (state == RD_RX) && (ph == 2'd3);
    rx_data  = rx_valid ? rdata_q : 8'h00;
    rx_last  = rx_valid && (cnt == 4'd0);
    done     = (state == DONE);
    err      = done && err_q;
    for (int i = 0; i < NREQ; i++)
      gnt[i] = (state != IDLE) && (state != ARB) && (gidx == GW'(i));
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small SPI IP register model.
// POLL_MAX=5 so the slow-status case (ready on the 5th read) and the timeout
// case (5 failed reads) sit on either side of the same limit.
module tb_spi_txn_arbiter;
  localparam int NREQ = 2;
  localparam int PMAX = 5;

  logic              I_CLK = 1'b0;
  logic              I_RESET = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_ssmask = '0;
  logic [4*NREQ-1:0] req_len = '0;
  logic [8*NREQ-1:0] tx_data;
  logic [NREQ-1:0]   gnt;
  logic              tx_take, rx_valid, rx_last, done, err;
  logic [7:0]        rx_data;
  logic              I_TX_EN, I_RX_EN;
  logic [2:0]        I_WADDR, I_RADDR;
  logic [7:0]        I_WDATA;
  logic [7:0]        O_RDATA = 8'h00;

  always #5 I_CLK = ~I_CLK;

  spi_txn_arbiter #(.NREQ(NREQ), .CTRL_ON(8'h8B), .POLL_MAX(PMAX)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .req(req), .req_ssmask(req_ssmask),
    .req_len(req_len), .tx_data(tx_data), .gnt(gnt), .tx_take(tx_take),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .done(done),
    .err(err), .I_TX_EN(I_TX_EN), .I_WADDR(I_WADDR), .I_WDATA(I_WDATA),
    .I_RX_EN(I_RX_EN), .I_RADDR(I_RADDR), .O_RDATA(O_RDATA));

  int tests = 0;
  int fails = 0;

  // requester TX byte tables
  logic [7:0] tx0 [16];
  logic [7:0] tx1 [16];
  int ti0 = 0, ti1 = 0;
  assign tx_data = {tx1[ti1 & 15], tx0[ti0 & 15]};

  // IP model: status fails pend_fail times per poll phase, then reports ready.
  // RXDATA returns last TXDATA + 8'h50.
  int         tx_fail_n = 0, rx_fail_n = 0;
  int         pend_fail = 0;
  logic       rx_phase = 1'b0;
  logic [7:0] last_tx = 8'h00;
  always @(posedge I_CLK) begin
    if (I_TX_EN && I_WADDR == 3'd1) begin
      last_tx <= I_WDATA; rx_phase <= 1'b1; pend_fail <= rx_fail_n;
    end
    if (I_TX_EN && I_WADDR == 3'd3) begin
      rx_phase <= 1'b0; pend_fail <= tx_fail_n;
    end
    if (I_RX_EN) begin
      if (I_RADDR == 3'd2) begin
        if (pend_fail > 0) begin
          O_RDATA <= rx_phase ? 8'h30 : 8'h10;
          pend_fail <= pend_fail - 1;
        end else O_RDATA <= rx_phase ? 8'h40 : 8'h30;
      end else if (I_RADDR == 3'd0) begin
        O_RDATA <= last_tx + 8'h50; rx_phase <= 1'b0; pend_fail <= tx_fail_n;
      end else O_RDATA <= 8'hEE;
    end
  end

  // monitor, sampling 2 time units after each rising edge
  logic [11:0] bus_q [$];
  logic [8:0]  rx_q [$];
  int          order_q [$];
  int          len_q [$];
  int          take_n = 0, done_n = 0, err_n = 0, both_n = 0, dbl_n = 0, cur_len = 0;
  logic        tx_prev = 1'b0, rx_prev = 1'b0;
  logic [NREQ-1:0] gnt_prev = '0;
  always @(posedge I_CLK) begin
    #2;
    if (I_TX_EN) bus_q.push_back({1'b1, I_WADDR, I_WDATA});
    if (I_RX_EN) bus_q.push_back({1'b0, I_RADDR, 8'h00});
    if (I_TX_EN && I_RX_EN) both_n++;
    if ((I_TX_EN && tx_prev) || (I_RX_EN && rx_prev)) dbl_n++;
    tx_prev = I_TX_EN;
    rx_prev = I_RX_EN;
    if (tx_take) begin
      take_n++;
      if (gnt[1]) ti1++; else ti0++;
    end
    if (rx_valid) rx_q.push_back({rx_last, rx_data});
    if (done) begin done_n++; if (err) err_n++; end
    if (gnt != '0) begin
      if (gnt_prev == '0) order_q.push_back(gnt[1] ? 1 : 0);
      cur_len++;
    end else if (gnt_prev != '0) begin
      len_q.push_back(cur_len);
      cur_len = 0;
    end
    gnt_prev = gnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, gnt, tx_take, rx_valid, rx_last, done, err, I_TX_EN, I_RX_EN,
            I_WADDR, I_RADDR, I_WDATA, rx_data};
  endfunction

  function automatic logic [11:0] W(input logic [2:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic logic [11:0] R(input logic [2:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  logic [11:0] exp_q [$];

  task automatic cmp_bus(input string tag);
    chk({tag, "_nops"}, bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
      chk($sformatf("%s_op%0d", tag, i), {20'h0, bus_q[i]}, {20'h0, exp_q[i]});
  endtask

  task automatic clear_logs();
    bus_q.delete(); rx_q.delete(); order_q.delete(); len_q.delete(); exp_q.delete();
    take_n = 0; done_n = 0; err_n = 0; ti0 = 0; ti1 = 0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int c;
    @(negedge I_CLK);
    c = 1;
    while (!done && c < bound) begin
      @(negedge I_CLK);
      c++;
    end
    chk({tag, "_done_seen"}, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin tx0[i] = 8'h00; tx1[i] = 8'h00; end

    // ---- reset state
    repeat (3) @(negedge I_CLK);
    chk("reset_outputs", outs(), 32'h0);
    I_RESET = 1'b0;
    @(negedge I_CLK);
    chk("idle_outputs", outs(), 32'h0);

    // ---- single byte, req0, len=0
    clear_logs();
    req_ssmask = {8'h02, 8'h01};
    req_len    = {4'd3, 4'd0};
    tx0[0] = 8'h55;
    req = 2'b01;
    @(negedge I_CLK);
    chk("t1_arb_no_gnt", {30'h0, gnt}, 32'h0);
    @(negedge I_CLK);
    chk("t1_gnt_latency", {30'h0, gnt}, 32'h1);
    chk("t1_ss_strobe", {20'h0, I_TX_EN, I_WADDR, I_WDATA}, {20'h0, 1'b1, 3'd4, 8'h01});
    wait_done(100, "t1");
    chk("t1_err", {31'h0, err}, 32'h0);
    req = 2'b00;
    repeat (2) @(negedge I_CLK);
    exp_q = '{W(4, 8'h01), W(3, 8'h8B), R(2), W(1, 8'h55), R(2), R(0), W(3, 8'h00)};
    cmp_bus("t1");
    chk("t1_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t1_rx0", {23'h0, rx_q[0]}, {23'h0, 1'b1, 8'hA5});
    chk("t1_gnt_len", (len_q.size() > 0) ? len_q[0] : -1, 21);
    chk("t1_take_n", take_n, 1);

    // ---- burst, req1, len=3
    clear_logs();
    tx1[0] = 8'h11; tx1[1] = 8'h22; tx1[2] = 8'h33; tx1[3] = 8'h44;
    req = 2'b10;
    wait_done(200, "t2");
    chk("t2_err", {31'h0, err}, 32'h0);
    req = 2'b00;
    repeat (2) @(negedge I_CLK);
    exp_q = '{W(4, 8'h02), W(3, 8'h8B)};
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(R(2)); exp_q.push_back(W(1, tx1[b]));
      exp_q.push_back(R(2)); exp_q.push_back(R(0));
    end
    exp_q.push_back(W(3, 8'h00));
    cmp_bus("t2");
    chk("t2_take_n", take_n, 4);
    chk("t2_rx_n", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      chk("t2_rx0", {23'h0, rx_q[0]}, {23'h0, 1'b0, 8'h61});
      chk("t2_rx1", {23'h0, rx_q[1]}, {23'h0, 1'b0, 8'h72});
      chk("t2_rx2", {23'h0, rx_q[2]}, {23'h0, 1'b0, 8'h83});
      chk("t2_rx3", {23'h0, rx_q[3]}, {23'h0, 1'b1, 8'h94});
    end
    chk("t2_order", (order_q.size() > 0) ? order_q[0] : -1, 1);
    chk("t2_gnt_len", (len_q.size() > 0) ? len_q[0] : -1, 63);

    // ---- round robin, both held
    clear_logs();
    req_len = {4'd0, 4'd0};
    req = 2'b11;
    for (int n = 0; n < 4; n++) wait_done(100, $sformatf("t3_%0d", n));
    req = 2'b00;
    repeat (2) @(negedge I_CLK);
    chk("t3_n_grants", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("t3_g0", order_q[0], 0);
      chk("t3_g1", order_q[1], 1);
      chk("t3_g2", order_q[2], 0);
      chk("t3_g3", order_q[3], 1);
    end
    chk("t3_len1", (len_q.size() > 1) ? len_q[1] : -1, 21);

    // ---- slow status: RX ready on the 5th read
    clear_logs();
    tx0[0] = 8'h3C;
    rx_fail_n = 4;
    req = 2'b01;
    wait_done(200, "t4");
    chk("t4_err", {31'h0, err}, 32'h0);
    req = 2'b00;
    rx_fail_n = 0;
    repeat (2) @(negedge I_CLK);
    exp_q = '{W(4, 8'h01), W(3, 8'h8B), R(2), W(1, 8'h3C),
              R(2), R(2), R(2), R(2), R(2), R(0), W(3, 8'h00)};
    cmp_bus("t4");
    chk("t4_rx", (rx_q.size() > 0) ? {23'h0, rx_q[0]} : 32'hFFFF, {23'h0, 1'b1, 8'h8C});
    chk("t4_gnt_len", (len_q.size() > 0) ? len_q[0] : -1, 37);

    // ---- timeout: TX never ready, len=2 so remaining bytes are skipped
    clear_logs();
    req_len = {4'd0, 4'd2};
    tx_fail_n = 255;
    req = 2'b01;
    wait_done(200, "t5");
    chk("t5_err", {31'h0, err}, 32'h1);
    req = 2'b00;
    tx_fail_n = 0;
    repeat (2) @(negedge I_CLK);
    exp_q = '{W(4, 8'h01), W(3, 8'h8B), R(2), R(2), R(2), R(2), R(2), W(3, 8'h00)};
    cmp_bus("t5");
    chk("t5_take_n", take_n, 0);
    chk("t5_rx_n", rx_q.size(), 0);
    chk("t5_done_n", done_n, 1);
    chk("t5_gnt_len", (len_q.size() > 0) ? len_q[0] : -1, 27);

    // ---- reset mid-burst after byte 1, then requester 0 wins
    clear_logs();
    req_len = {4'd3, 4'd0};
    req = 2'b10;
    begin
      int c;
      c = 0;
      while (rx_q.size() < 1 && c < 200) begin @(negedge I_CLK); c++; end
      chk("t6_first_byte", rx_q.size(), 1);
    end
    req = 2'b11;
    I_RESET = 1'b1;
    @(negedge I_CLK);
    I_RESET = 1'b0;
    chk("t6_reset_outputs", outs(), 32'h0);
    repeat (2) @(negedge I_CLK);
    chk("t6_gnt_after_reset", {30'h0, gnt}, 32'h1);
    wait_done(100, "t6");
    req = 2'b00;
    repeat (2) @(negedge I_CLK);
    chk("t6_rx_n", rx_q.size(), 2);

    // ---- bus protocol over the whole run
    chk("strobe_overlap", both_n, 0);
    chk("strobe_width", dbl_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
